// File: rtl/maxpool_2x2.sv
`default_nettype none
// ============================================================================
//  Module      : maxpool_2x2
//  Description : Streaming per-channel 2x2 max pooling, stride 2, for a
//                raster-ordered (row-major) feature map of
//                IN_HEIGHT x IN_WIDTH positions with NUM_FILTERS parallel
//                signed channels.
//
//                Each pooled position is produced one cycle after the input
//                beat at (odd row, odd column) of its window. A hold register
//                keeps the even-column sample. A row buffer of IN_WIDTH/2
//                entries carries the even-row horizontal maxima down to the
//                odd row.
//
//  Ports       : i_clk            - clock, all logic on rising edge
//                i_rst            - synchronous active-high reset
//                i_feature_valid  - i_features carries one pixel position
//                i_features       - NUM_FILTERS x FEATURE_WIDTH signed inputs
//                o_feature_valid  - one-cycle pulse per pooled position
//                o_features       - pooled maxima, held between pulses
//                o_last           - final pooled position of a frame
//
//  Revision    : 1.0 - initial release
// ============================================================================
module maxpool_2x2 #(
    parameter int NUM_FILTERS   = 6,
    parameter int FEATURE_WIDTH = 16,
    parameter int IN_WIDTH      = 28,
    parameter int IN_HEIGHT     = 28
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic                                        i_feature_valid,
    input  logic [NUM_FILTERS-1:0][FEATURE_WIDTH-1:0]   i_features,
    output logic                                        o_feature_valid,
    output logic [NUM_FILTERS-1:0][FEATURE_WIDTH-1:0]   o_features,
    output logic                                        o_last
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_COL_W     = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
    localparam int c_ROW_W     = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int c_BUF_DEPTH = IN_WIDTH / 2;
    localparam int c_BUF_W     = (c_BUF_DEPTH > 1) ? $clog2(c_BUF_DEPTH) : 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IN_WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IN_HEIGHT - 1);
    localparam logic [c_COL_W-1:0] c_COL_ONE  = c_COL_W'(1);
    localparam logic [c_ROW_W-1:0] c_ROW_ONE  = c_ROW_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_COL_W-1:0]                         r_col;
    logic [c_ROW_W-1:0]                         r_row;
    logic [NUM_FILTERS-1:0][FEATURE_WIDTH-1:0]  r_hold;
    logic [NUM_FILTERS-1:0][FEATURE_WIDTH-1:0]  r_rowbuf [c_BUF_DEPTH];
    logic [NUM_FILTERS-1:0][FEATURE_WIDTH-1:0]  r_out;
    logic                                       r_valid;
    logic                                       r_last;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [c_COL_W-1:0]                         w_col_next;
    logic [c_ROW_W-1:0]                         w_row_next;
    logic                                       w_beat;
    logic                                       w_col_odd;
    logic                                       w_row_odd;
    logic                                       w_col_end;
    logic                                       w_row_end;
    logic                                       w_hold_we;
    logic                                       w_buf_we;
    logic                                       w_out_fire;
    logic                                       w_frame_end;
    logic [c_BUF_W-1:0]                         w_buf_idx;
    logic [NUM_FILTERS-1:0][FEATURE_WIDTH-1:0]  w_buf_rd;
    logic [NUM_FILTERS-1:0][FEATURE_WIDTH-1:0]  w_hmax;
    logic [NUM_FILTERS-1:0][FEATURE_WIDTH-1:0]  w_pool;

    // Input beats are ignored entirely while reset is held.
    assign w_beat      = i_feature_valid & ~i_rst;
    assign w_col_odd   = r_col[0];
    assign w_row_odd   = r_row[0];
    assign w_col_end   = (r_col == c_COL_LAST);
    assign w_row_end   = (r_row == c_ROW_LAST);

    assign w_hold_we   = w_beat & ~w_col_odd;
    assign w_buf_we    = w_beat &  w_col_odd & ~w_row_odd;
    assign w_out_fire  = w_beat &  w_col_odd &  w_row_odd;
    assign w_frame_end = w_out_fire & w_col_end & w_row_end;

    // Window column index: one row-buffer entry per pair of input columns.
    assign w_buf_idx   = c_BUF_W'(r_col >> 1);
    assign w_buf_rd    = r_rowbuf[w_buf_idx];

    // ------------------------------------------------------------------------
    // Per-channel signed comparators
    // ------------------------------------------------------------------------
    generate
        for (genvar g = 0; g < NUM_FILTERS; g++) begin : g_chan
            // Horizontal max of the even-column hold and the odd-column input.
            assign w_hmax[g] = ($signed(r_hold[g]) > $signed(i_features[g]))
                             ? r_hold[g] : i_features[g];
            // Vertical max against the even row stored for this window.
            assign w_pool[g] = ($signed(w_buf_rd[g]) > $signed(w_hmax[g]))
                             ? w_buf_rd[g] : w_hmax[g];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Raster position counters: advance only on accepted beats
    // ------------------------------------------------------------------------
    always_comb begin
        w_col_next = r_col;
        w_row_next = r_row;
        if (w_beat) begin
            if (w_col_end) begin
                w_col_next = '0;
                // Row wrap marks the frame boundary; there is no frame-start
                // input, so the next beat is pixel (0,0) of a new frame.
                w_row_next = w_row_end ? '0 : (r_row + c_ROW_ONE);
            end else begin
                w_col_next = r_col + c_COL_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_out   <= '0;
        end else begin
            r_col   <= w_col_next;
            r_row   <= w_row_next;
            r_valid <= w_out_fire;
            r_last  <= w_frame_end;
            if (w_out_fire) begin
                r_out <= w_pool;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Datapath storage. No reset: within every frame each hold/row-buffer
    // entry is written (even column / even row) before it is read (odd
    // column / odd row), and a reset restarts the frame at pixel (0,0).
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_hold_we) begin
            r_hold <= i_features;
        end
        if (w_buf_we) begin
            r_rowbuf[w_buf_idx] <= w_hmax;
        end
    end

    assign o_feature_valid = r_valid;
    assign o_features      = r_out;
    assign o_last          = r_last;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_2x2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maxpool_2x2
//  Description : Directed self-checking bench for maxpool_2x2 (28x28 map,
//                6 channels, 16-bit signed). Pixel patterns and the expected
//                pooled value of each window are written as closed-form
//                formulas per pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_maxpool_2x2;

    localparam int NF = 6;
    localparam int FW = 16;
    localparam int W  = 28;
    localparam int H  = 28;

    typedef logic [NF-1:0][FW-1:0] feat_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  in_valid;
    feat_t in_f;
    logic  out_valid;
    feat_t out_f;
    logic  out_last;

    int    n_chk = 0;
    int    n_err = 0;
    feat_t held;          // value o_features must currently show
    int    dut_out_cnt;   // outputs seen from the DUT in the current frame
    int    dut_last_at;   // output index at which the DUT raised o_last

    always #5 clk = ~clk;

    maxpool_2x2 #(
        .NUM_FILTERS   (NF),
        .FEATURE_WIDTH (FW),
        .IN_WIDTH      (W),
        .IN_HEIGHT     (H)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_feature_valid (in_valid),
        .i_features      (in_f),
        .o_feature_valid (out_valid),
        .o_features      (out_f),
        .o_last          (out_last)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pixel value of channel c at (r,x).
    //  mode 0: ramp 100*r + x + c + off
    //  mode 1: window (2,3) holds 500 at position (p+c)%4, everything else -3
    //  mode 2: -32768 everywhere except pixel (11,18) = -1
    function automatic int pix(input int mode, input int p, input int off,
                               input int r, input int x, input int c);
        if (mode == 0) return 100 * r + x + c + off;
        if (mode == 1) begin
            if ((r / 2 == 2) && (x / 2 == 3) && ((r % 2) * 2 + (x % 2) == (p + c) % 4))
                return 500;
            return -3;
        end
        if (r == 11 && x == 18) return -1;
        return -32768;
    endfunction

    // Hand-derived pooled value for output (i,j) of channel c.
    function automatic int exp_out(input int mode, input int off,
                                   input int i, input int j, input int c);
        if (mode == 0) return 100 * (2 * i + 1) + 2 * j + 1 + c + off;
        if (mode == 1) return (i == 2 && j == 3) ? 500 : -3;
        return (i == 5 && j == 9) ? -1 : -32768;
    endfunction

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_f     = {$urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        chk("idle_valid", out_valid, 0);
        chk("idle_hold",  out_f,     held);
        chk("idle_last",  out_last,  0);
    endtask

    task automatic beat(input feat_t f, input bit ev, input feat_t ef,
                        input bit el, input string tag);
        in_valid = 1'b1;
        in_f     = f;
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, out_valid, ev);
        if (ev) held = ef;
        chk({tag, "_data"}, out_f,    held);
        chk({tag, "_last"}, out_last, el);
        if (out_valid === 1'b1) dut_out_cnt++;
        if (out_last  === 1'b1) dut_last_at = dut_out_cnt;
    endtask

    task automatic frame(input int mode, input int p, input int off, input bit gaps,
                         input int n_beats, input string tag);
        int    r;
        int    x;
        feat_t f;
        feat_t ef;
        bit    ev;
        bit    el;
        dut_out_cnt = 0;
        dut_last_at = 0;
        for (int k = 0; k < n_beats; k++) begin
            r = k / W;
            x = k % W;
            if (gaps) begin
                if ($urandom_range(1) == 1) idle_cycle();
                if ($urandom_range(15) == 0) repeat (3) idle_cycle();
            end
            for (int c = 0; c < NF; c++) begin
                f[c]  = 16'(pix(mode, p, off, r, x, c));
                ef[c] = 16'(exp_out(mode, off, r / 2, x / 2, c));
            end
            ev = (r % 2 == 1) && (x % 2 == 1);
            el = ev && (r == H - 1) && (x == W - 1);
            beat(f, ev, ef, el, tag);
        end
        if (n_beats == W * H) begin
            chk({tag, "_count"},   dut_out_cnt, (W / 2) * (H / 2));
            chk({tag, "_last_at"}, dut_last_at, (W / 2) * (H / 2));
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;     // must be ignored under reset
        in_f     = '1;
        held     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_data",  out_f,     0);
        chk("reset_last",  out_last,  0);
        rst = 1'b0;

        // Ramp, valid every cycle
        frame(0, 0, 0, 1'b0, W * H, "ramp");
        idle_cycle();

        // Ramp with random valid gaps
        frame(0, 0, 0, 1'b1, W * H, "gaps");
        idle_cycle();

        // Maximum in each window position in turn (ties of -3 elsewhere)
        for (int p = 0; p < 4; p++) frame(1, p, 0, 1'b0, W * H, "maxpos");

        // Most-negative values with a single -1
        frame(2, 0, 0, 1'b0, W * H, "neg");

        // Back-to-back frames, no dead cycle between them
        frame(0, 0, 0,    1'b0, W * H, "b2b_a");
        frame(0, 0, 1000, 1'b0, W * H, "b2b_b");

        // Reset after 300 beats, then a full frame
        frame(0, 0, 0, 1'b0, 300, "partial");
        rst      = 1'b1;
        in_valid = 1'b1;
        in_f     = {$urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        held = '0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data",  out_f,     0);
        chk("midrst_last",  out_last,  0);
        rst = 1'b0;
        frame(0, 0, 0, 1'b0, W * H, "after_rst");
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/maxpool_2x2.md
MAXPOOL_2X2 -- requirements
Module: maxpool_2x2

Interface
REQ-001 Parameter NUM_FILTERS, default 6: number of parallel feature channels.
REQ-002 Parameter FEATURE_WIDTH, default 16: signed width of each channel value.
REQ-003 Parameter IN_WIDTH, default 28: input feature-map columns; even, >=2.
REQ-004 Parameter IN_HEIGHT, default 28: input feature-map rows; even, >=2.
REQ-005 i_clk  input  1: single clock; all logic on rising edge.
REQ-006 i_rst  input  1: synchronous, active-high reset.
REQ-007 i_feature_valid  input  1: i_features carries one pixel position (all channels) this cycle.
REQ-008 i_features  input  NUM_FILTERS x FEATURE_WIDTH signed: conv output channels, raster order, row-major.
REQ-009 o_feature_valid  output  1: o_features holds one pooled position this cycle.
REQ-010 o_features  output  NUM_FILTERS x FEATURE_WIDTH signed: 2x2 max per channel.
REQ-011 o_last  output  1: high with o_feature_valid on the final pooled position of a frame.

Function
REQ-012 Block shall perform per-channel 2x2 max pooling, stride 2: output (IN_HEIGHT/2) x (IN_WIDTH/2) positions per frame.
REQ-013 Column counter (0..IN_WIDTH-1) and row counter (0..IN_HEIGHT-1) shall advance only on cycles with i_feature_valid=1; gaps of any length shall not alter state.
REQ-014 Column counter shall wrap to 0 after IN_WIDTH-1 and increment row; row shall wrap to 0 after IN_HEIGHT-1 (frame boundary). No frame-start input exists.
REQ-015 Even column beat: per channel, sample captured into a hold register.
REQ-016 Odd column beat: horizontal max h = max(hold, input) per channel, computed by signed comparison.
REQ-017 Even row, odd column: h shall be written to row-buffer entry col/2 (depth IN_WIDTH/2, NUM_FILTERS x FEATURE_WIDTH wide).
REQ-018 Odd row, odd column: per channel, the result max(h, rowbuf[col/2]) shall be registered to o_features, and o_feature_valid shall be pulsed for exactly one cycle.
REQ-019 Latency: o_feature_valid shall assert the cycle after the input beat at (odd row, odd column); exactly one output per such beat.
REQ-020 o_features shall hold its last value while o_feature_valid=0.
REQ-021 o_last shall assert only with the output from input position (IN_HEIGHT-1, IN_WIDTH-1); otherwise 0.
REQ-022 Ties shall produce the equal value; no arithmetic shall be applied (no saturation, no rounding, width preserved).
REQ-023 Most-negative value (-2^(FEATURE_WIDTH-1)) shall compare correctly; signed ordering throughout.
REQ-024 No backpressure: downstream shall accept every o_feature_valid pulse; block shall sustain i_feature_valid=1 every cycle.
REQ-025 Back-to-back frames shall pool with no dead cycles; row-buffer contents of a new frame shall be fully overwritten by its row 0 before being read in row 1.

Reset
REQ-026 During i_rst=1: counters=0, o_feature_valid=0, o_last=0, o_features=0; i_feature_valid ignored.
REQ-027 Row buffer and hold register need not be reset; they shall never be read before being written in the current frame.
REQ-028 Reset mid-frame shall abandon the partial frame; the first input beat after release is treated as pixel (0,0) and no output occurs before row 1, column 1 of the new frame.

Verification
REQ-029 Ramp: channel c, pixel (r,x) = 100*r + x + c, valid every cycle, 28x28 -> 196 outputs; output (i,j) = 100*(2i+1) + 2j+1 + c; o_last only on output 196.
REQ-030 Position of max: 2x2 window with max 500 placed in each of the four positions in turn, others -3 -> output 500 each time.
REQ-031 Negative/signed: all inputs -32768 except one window with -1 -> that output -1, all others -32768.
REQ-032 Valid gaps: ramp frame with i_feature_valid random ~50% -> outputs identical in value and order to REQ-029; each valid pulse exactly one cycle after its triggering beat.
REQ-033 Reset mid-frame: assert i_rst for 1 cycle after 300 beats, then full ramp frame -> no output during or after reset until new row 1 col 1; then 196 correct outputs.
REQ-034 Back-to-back: two consecutive frames, second frame ramp plus 1000 -> 392 outputs, o_last at 196 and 392, second-frame values +1000 with no first-frame contamination.
